// File: rtl/vliw_issue_scheduler.sv
// vliw_issue_scheduler: issue control for the two-slot ALU+MEM bundle.
// Tracks in-flight loads, stalls on RAW/WAW, runs exception drain/redirect.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   bundle_valid/ready    decode handshake (ready only while running)
//   bundle_pc             PC of presented bundle
//   alu_rm/rn/rd, aluSrcB, alu_regWrite, alu_undefinedInstruction
//                         ALU slot decode
//   mem_rn/rd, memRead, memWrite, mem_undefinedInstruction
//                         MEM slot decode
//   issue, alu_wr_en      bundle accepted / ALU register write enable
//   mem_wb_en, mem_wb_rd  load write-back pulse and destination
//   redirect_valid/pc     one-cycle fetch redirect to the exception vector
//   epc, exc_cause        faulting PC and cause, held until next fault
module vliw_issue_scheduler #(
    parameter int unsigned LOAD_LAT   = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h00FF00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bundle_valid,
    output logic        bundle_ready,
    input  logic [31:0] bundle_pc,
    input  logic [2:0]  alu_rm,
    input  logic [2:0]  alu_rn,
    input  logic [2:0]  alu_rd,
    input  logic        aluSrcB,
    input  logic        alu_regWrite,
    input  logic        alu_undefinedInstruction,
    input  logic [2:0]  mem_rn,
    input  logic [2:0]  mem_rd,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        mem_undefinedInstruction,
    output logic        issue,
    output logic        alu_wr_en,
    output logic        mem_wb_en,
    output logic [2:0]  mem_wb_rd,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause
);

    localparam logic [2:0] LAT = 3'(LOAD_LAT);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_VECTOR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q [8];
    logic [2:0]  cnt_d [8];
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;

    logic [7:0]  busy;
    logic        all_idle;
    logic        hazard;
    logic [1:0]  fault_cause;
    logic        fault;
    logic        issue_int;
    logic        load_issue;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            busy[i] = (cnt_q[i] != 3'd0);
        end
    end

    assign all_idle = (busy == 8'd0);

    // Source operands first, then destinations still owed by a load (WAW).
    always_comb begin
        hazard = busy[alu_rn];
        if (!aluSrcB)
            hazard = hazard | busy[alu_rm];
        if (memRead || memWrite)
            hazard = hazard | busy[mem_rn];
        if (memWrite)
            hazard = hazard | busy[mem_rd];
        if (alu_regWrite)
            hazard = hazard | busy[alu_rd];
        if (memRead)
            hazard = hazard | busy[mem_rd];
    end

    // Two writes to one register in the same bundle is treated as a fault.
    always_comb begin
        fault_cause = 2'b00;
        if (alu_undefinedInstruction)
            fault_cause = 2'b01;
        else if (mem_undefinedInstruction)
            fault_cause = 2'b10;
        else if (alu_regWrite && memRead && (alu_rd == mem_rd))
            fault_cause = 2'b11;
    end

    assign fault = (fault_cause != 2'b00);

    // A faulting bundle never stalls: fault wins over hazard.
    assign issue_int = reset && (state_q == S_RUN) && bundle_valid
                       && !fault && !hazard;
    assign load_issue = issue_int && memRead;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (load_issue && (mem_rd == 3'(i)))
                cnt_d[i] = LAT;
            else if (busy[i])
                cnt_d[i] = cnt_q[i] - 3'd1;
            else
                cnt_d[i] = 3'd0;
        end
    end

    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        if ((state_q == S_RUN) && bundle_valid && fault) begin
            epc_d   = bundle_pc;
            cause_d = fault_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // DRAIN checks the current counters, so an empty scoreboard
    // still costs exactly one DRAIN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (bundle_valid && fault)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (all_idle)
                    state_d = S_VECTOR;
            end
            S_VECTOR: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Pulses are gated by reset so a pending write-back is dropped
    // in the very cycle reset is applied.
    always_comb begin
        bundle_ready   = (state_q == S_RUN);
        issue          = issue_int;
        alu_wr_en      = issue_int && alu_regWrite;
        redirect_valid = reset && (state_q == S_VECTOR);
        redirect_pc    = redirect_valid ? EXC_VECTOR : 32'd0;
        mem_wb_en      = 1'b0;
        mem_wb_rd      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (reset && (cnt_q[i] == 3'd1)) begin
                mem_wb_en = 1'b1;
                mem_wb_rd = 3'(i);
            end
        end
    end

    assign epc       = epc_q;
    assign exc_cause = cause_q;

endmodule

// File: tb/tb_vliw_issue_scheduler.sv
// Directed bench for vliw_issue_scheduler.
// Load latency 2: a load issued in cycle N writes back in cycle N+2.
module tb_vliw_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        bundle_valid;
    logic        bundle_ready;
    logic [31:0] bundle_pc;
    logic [2:0]  alu_rm, alu_rn, alu_rd;
    logic        aluSrcB, alu_regWrite, alu_undefinedInstruction;
    logic [2:0]  mem_rn, mem_rd;
    logic        memRead, memWrite, mem_undefinedInstruction;
    logic        issue, alu_wr_en, mem_wb_en;
    logic [2:0]  mem_wb_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc, epc;
    logic [1:0]  exc_cause;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vliw_issue_scheduler dut (
        .clk                      (clk),
        .reset                    (reset),
        .bundle_valid             (bundle_valid),
        .bundle_ready             (bundle_ready),
        .bundle_pc                (bundle_pc),
        .alu_rm                   (alu_rm),
        .alu_rn                   (alu_rn),
        .alu_rd                   (alu_rd),
        .aluSrcB                  (aluSrcB),
        .alu_regWrite             (alu_regWrite),
        .alu_undefinedInstruction (alu_undefinedInstruction),
        .mem_rn                   (mem_rn),
        .mem_rd                   (mem_rd),
        .memRead                  (memRead),
        .memWrite                 (memWrite),
        .mem_undefinedInstruction (mem_undefinedInstruction),
        .issue                    (issue),
        .alu_wr_en                (alu_wr_en),
        .mem_wb_en                (mem_wb_en),
        .mem_wb_rd                (mem_wb_rd),
        .redirect_valid           (redirect_valid),
        .redirect_pc              (redirect_pc),
        .epc                      (epc),
        .exc_cause                (exc_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bundle_valid = 0; bundle_pc = 0;
        alu_rm = 0; alu_rn = 0; alu_rd = 0;
        aluSrcB = 1; alu_regWrite = 0; alu_undefinedInstruction = 0;
        mem_rn = 0; mem_rd = 0; memRead = 0; memWrite = 0;
        mem_undefinedInstruction = 0;
    endtask

    task automatic ld(input logic [2:0] rd);
        idle();
        bundle_valid = 1; memRead = 1; mem_rd = rd; mem_rn = 3'd0;
    endtask

    task automatic st(input logic [2:0] rd);
        idle();
        bundle_valid = 1; memWrite = 1; mem_rd = rd; mem_rn = 3'd0;
    endtask

    task automatic alu(input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic srcb);
        idle();
        bundle_valid = 1; alu_regWrite = 1;
        alu_rd = rd; alu_rn = rn; alu_rm = rm; aluSrcB = srcb;
    endtask

    initial begin
        idle();
        reset = 0;
        tick(); tick();
        reset = 1;
        settle();
        chk("rst_issue", 32'(issue), 0);
        chk("rst_aluwr", 32'(alu_wr_en), 0);
        chk("rst_wb", 32'(mem_wb_en), 0);
        chk("rst_wbrd", 32'(mem_wb_rd), 0);
        chk("rst_redir", 32'(redirect_valid), 0);
        chk("rst_epc", epc, 0);
        chk("rst_cause", 32'(exc_cause), 0);
        chk("rst_ready", 32'(bundle_ready), 1);

        // Load r3 then dependent ALU bundle.
        tick(); ld(3'd3); settle();
        chk("lu_ld_issue", 32'(issue), 1);
        chk("lu_ld_aluwr", 32'(alu_wr_en), 0);
        tick(); alu(3'd1, 3'd3, 3'd0, 1'b0); settle();
        chk("lu_stall1", 32'(issue), 0);
        chk("lu_stall1_wr", 32'(alu_wr_en), 0);
        chk("lu_nowb1", 32'(mem_wb_en), 0);
        tick(); settle();
        chk("lu_stall2", 32'(issue), 0);
        chk("lu_wb", 32'(mem_wb_en), 1);
        chk("lu_wbrd", 32'(mem_wb_rd), 3);
        tick(); settle();
        chk("lu_issue", 32'(issue), 1);
        chk("lu_aluwr", 32'(alu_wr_en), 1);
        chk("lu_wb_done", 32'(mem_wb_en), 0);

        // WAW: back-to-back loads to r5.
        tick(); ld(3'd5); settle();
        chk("waw_first", 32'(issue), 1);
        tick(); ld(3'd5); settle();
        chk("waw_stall1", 32'(issue), 0);
        tick(); settle();
        chk("waw_stall2", 32'(issue), 0);
        chk("waw_wb1", 32'(mem_wb_en), 1);
        tick(); settle();
        chk("waw_second", 32'(issue), 1);
        chk("waw_nowb", 32'(mem_wb_en), 0);
        tick(); idle(); settle();
        chk("waw_reload", 32'(mem_wb_en), 0);
        tick(); settle();
        chk("waw_wb2", 32'(mem_wb_en), 1);
        chk("waw_wb2rd", 32'(mem_wb_rd), 5);
        tick(); settle();
        chk("waw_quiet", 32'(mem_wb_en), 0);

        // Immediate operand ignores a busy alu_rm.
        tick(); ld(3'd1); settle();
        tick(); alu(3'd2, 3'd0, 3'd1, 1'b1); settle();
        chk("imm_issue", 32'(issue), 1);
        tick(); alu(3'd2, 3'd0, 3'd1, 1'b0); settle();
        chk("rm_stall", 32'(issue), 0);
        chk("rm_wbrd", 32'(mem_wb_rd), 1);
        tick(); settle();
        chk("rm_issue", 32'(issue), 1);

        // ALU undefined while r2 load pending.
        tick(); ld(3'd2); settle();
        tick(); alu(3'd7, 3'd2, 3'd0, 1'b1);
        alu_undefinedInstruction = 1; bundle_pc = 32'h40; settle();
        chk("exc_issue", 32'(issue), 0);
        chk("exc_aluwr", 32'(alu_wr_en), 0);
        tick(); alu(3'd6, 3'd0, 3'd0, 1'b1); settle();
        chk("dr1_ready", 32'(bundle_ready), 0);
        chk("dr1_issue", 32'(issue), 0);
        chk("dr1_wb", 32'(mem_wb_en), 1);
        chk("dr1_wbrd", 32'(mem_wb_rd), 2);
        chk("dr1_epc", epc, 32'h40);
        tick(); settle();
        chk("dr2_ready", 32'(bundle_ready), 0);
        chk("dr2_redir", 32'(redirect_valid), 0);
        chk("dr2_wb", 32'(mem_wb_en), 0);
        tick(); settle();
        chk("vec_redir", 32'(redirect_valid), 1);
        chk("vec_pc", redirect_pc, 32'h00FF00FF);
        chk("vec_ready", 32'(bundle_ready), 0);
        chk("vec_issue", 32'(issue), 0);
        chk("vec_cause", 32'(exc_cause), 1);
        tick(); settle();
        chk("post_ready", 32'(bundle_ready), 1);
        chk("post_redir", 32'(redirect_valid), 0);
        chk("post_issue", 32'(issue), 1);

        // Both slots illegal, empty scoreboard: one DRAIN cycle.
        tick(); alu(3'd1, 3'd0, 3'd0, 1'b1);
        alu_undefinedInstruction = 1; mem_undefinedInstruction = 1;
        bundle_pc = 32'h80; settle();
        chk("both_issue", 32'(issue), 0);
        chk("both_aluwr", 32'(alu_wr_en), 0);
        tick(); idle(); settle();
        chk("both_drain", 32'(bundle_ready), 0);
        chk("both_dr_redir", 32'(redirect_valid), 0);
        tick(); settle();
        chk("both_redir", 32'(redirect_valid), 1);
        chk("both_cause", 32'(exc_cause), 1);
        chk("both_epc", epc, 32'h80);

        // Write-port conflict.
        tick(); ld(3'd4); alu_regWrite = 1; alu_rd = 3'd4;
        bundle_pc = 32'hC0; settle();
        chk("wpc_issue", 32'(issue), 0);
        chk("wpc_aluwr", 32'(alu_wr_en), 0);
        tick(); idle(); settle();
        chk("wpc_nowb", 32'(mem_wb_en), 0);
        tick(); settle();
        chk("wpc_redir", 32'(redirect_valid), 1);
        chk("wpc_cause", 32'(exc_cause), 3);
        chk("wpc_epc", epc, 32'hC0);
        tick(); settle();
        chk("wpc_nowb2", 32'(mem_wb_en), 0);

        // MEM slot undefined alone.
        tick(); st(3'd0); mem_undefinedInstruction = 1;
        bundle_pc = 32'h100; settle();
        chk("mu_issue", 32'(issue), 0);
        tick(); idle(); settle();
        tick(); settle();
        chk("mu_redir", 32'(redirect_valid), 1);
        chk("mu_cause", 32'(exc_cause), 2);

        // Store reading a register whose load is about to complete.
        tick(); ld(3'd6); settle();
        tick(); idle(); settle();
        tick(); st(3'd6); settle();
        chk("st_stall", 32'(issue), 0);
        chk("st_wbrd", 32'(mem_wb_rd), 6);
        tick(); settle();
        chk("st_issue", 32'(issue), 1);
        chk("st_nowb", 32'(mem_wb_en), 0);
        tick(); idle(); settle();
        chk("st_sb_clean", 32'(mem_wb_en), 0);
        tick(); settle();
        chk("st_sb_clean2", 32'(mem_wb_en), 0);

        // Reset applied during DRAIN while an r1 load is outstanding.
        tick(); ld(3'd1); settle();
        tick(); alu(3'd0, 3'd0, 3'd0, 1'b1);
        alu_undefinedInstruction = 1; bundle_pc = 32'h200; settle();
        chk("rd_fault", 32'(issue), 0);
        tick(); idle(); reset = 0; settle();
        chk("rd_drain", 32'(bundle_ready), 0);
        chk("rd_nowb", 32'(mem_wb_en), 0);
        tick(); reset = 1; settle();
        chk("rd_ready", 32'(bundle_ready), 1);
        chk("rd_redir", 32'(redirect_valid), 0);
        chk("rd_nowb2", 32'(mem_wb_en), 0);
        chk("rd_epc", epc, 0);
        chk("rd_cause", 32'(exc_cause), 0);
        tick(); settle();
        chk("rd_redir2", 32'(redirect_valid), 0);
        chk("rd_nowb3", 32'(mem_wb_en), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
